// File: rtl/user_input_pkg.sv
// user_input_pkg
//   Shared types and constants for the user_input button conditioner.
//   - user_input_state_t : Moore edge-detector states (IDLE, PULSE, HELD)
//   - USER_INPUT_SYNC_STAGES : depth of the optional input synchronizer
package user_input_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HELD  = 2'd2
    } user_input_state_t;

    localparam int unsigned USER_INPUT_SYNC_STAGES = 2;

endpackage

// File: rtl/input_filter.sv
// input_filter
//   Optional synchronizer followed by a debounce filter. The filtered level f
//   only changes after STABLE_CYCLES consecutive samples that differ from it.
//   Build option: USER_INPUT_SYNC_EN inserts a two-flop synchronizer in front
//   of the filter (adds 2 cycles of latency).
// Ports
//   Clock  in   system clock, rising edge
//   Reset  in   synchronous, active-high reset
//   in     in   raw button level, 1 = pressed
//   f      out  debounced level (registered)
module input_filter
    import user_input_pkg::*;
#(
    parameter int STABLE_CYCLES = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic in,
    output logic f
);

    if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
        $fatal(1, "input_filter: STABLE_CYCLES must be >= 1");
    end

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          s;
    logic [CW-1:0] cnt;

`ifdef USER_INPUT_SYNC_EN
    logic [USER_INPUT_SYNC_STAGES-1:0] sync;

    always_ff @(posedge Clock) begin
        if (Reset)
            sync <= '0;
        else
            sync <= {sync[USER_INPUT_SYNC_STAGES-2:0], in};
    end

    assign s = sync[USER_INPUT_SYNC_STAGES-1];
`else
    assign s = in;
`endif

    // cnt holds the number of differing samples already seen; the sample that
    // would make it reach STABLE_CYCLES flips f instead of being counted.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            f   <= 1'b0;
            cnt <= '0;
        end else if (s != f) begin
            if (cnt == CNT_LAST) begin
                f   <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/user_input.sv
// user_input
//   Turns a button level into a single-cycle press pulse: input_filter
//   (optional synchronizer + debounce) feeding a three-state Moore edge
//   detector. Holding the button yields exactly one pulse per press.
//   Build option: USER_INPUT_SYNC_EN (see input_filter) adds 2 cycles latency.
// Parameters
//   STABLE_CYCLES  consecutive samples needed to change the filtered level (>= 1)
// Ports
//   Clock  in   system clock, rising edge
//   Reset  in   synchronous, active-high reset
//   in     in   raw button level, 1 = pressed
//   out    out  one-cycle press pulse, decoded from the state register
module user_input
    import user_input_pkg::*;
#(
    parameter int STABLE_CYCLES = 1
) (
    input  logic Clock,
    input  logic Reset,
    input  logic in,
    output logic out
);

    if (STABLE_CYCLES < 1) begin : g_bad_stable_cycles
        $fatal(1, "user_input: STABLE_CYCLES must be >= 1");
    end

    logic              f;
    user_input_state_t state;
    user_input_state_t state_nx;

    input_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .Clock(Clock),
        .Reset(Reset),
        .in   (in),
        .f    (f)
    );

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = f ? PULSE : IDLE;
            PULSE:   state_nx = f ? HELD  : IDLE;
            HELD:    state_nx = f ? HELD  : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    assign out = (state == PULSE);

endmodule

// File: tb/tb_user_input.sv
// tb_user_input
//   Drives two user_input instances (STABLE_CYCLES = 1 and 4) with the same
//   stimulus. A reference model predicts out after every edge; predictions are
//   queued when the edge is driven and compared on the following falling edge.
//   Per-scenario pulse counts are also checked against fixed expectations.
module tb_user_input;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic in    = 1'b0;
    logic out1;
    logic out4;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned pc1 = 0;
    int unsigned pc4 = 0;

    logic [1:0] exp_q[$];

    // reference model state, index 0 -> STABLE_CYCLES=1, index 1 -> 4
    logic        m_sy1[2];
    logic        m_sy2[2];
    logic        m_f[2];
    logic        m_fprev[2];
    logic        m_out[2];
    int unsigned m_run[2];

    always #5 Clock = ~Clock;

    user_input #(.STABLE_CYCLES(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .in(in), .out(out1)
    );

    user_input #(.STABLE_CYCLES(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .in(in), .out(out4)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // out after edge n is high exactly when f rose at edge n-1
    task automatic model_edge(input int m, input int unsigned sc, input logic rst, input logic din);
        logic s;
`ifdef USER_INPUT_SYNC_EN
        s = m_sy2[m];
`else
        s = din;
`endif
        if (rst) begin
            m_sy1[m] = 1'b0; m_sy2[m] = 1'b0; m_f[m] = 1'b0;
            m_fprev[m] = 1'b0; m_out[m] = 1'b0; m_run[m] = 0;
        end else begin
            m_out[m]   = m_f[m] & ~m_fprev[m];
            m_fprev[m] = m_f[m];
            if (s != m_f[m]) begin
                m_run[m]++;
                if (m_run[m] == sc) begin
                    m_f[m]   = s;
                    m_run[m] = 0;
                end
            end else begin
                m_run[m] = 0;
            end
            m_sy2[m] = m_sy1[m];
            m_sy1[m] = din;
        end
    endtask

    task automatic step(input logic rst, input logic din);
        @(negedge Clock);
        Reset = rst;
        in    = din;
        @(posedge Clock);
        model_edge(0, 1, rst, din);
        model_edge(1, 4, rst, din);
        exp_q.push_back({m_out[1], m_out[0]});
    endtask

    task automatic steps(input logic din, input int n);
        for (int i = 0; i < n; i++) step(1'b0, din);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge Clock);
            #1;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic scenario_end(input string tag, input int e1, input int e4);
        steps(1'b0, 10);
        drain();
        check({tag, "_pulses_s1"}, pc1, e1);
        check({tag, "_pulses_s4"}, pc4, e4);
        pc1 = 0;
        pc4 = 0;
    endtask

    always @(negedge Clock) begin
        logic [1:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_s1", int'(out1), int'(e[0]));
            check("out_s4", int'(out4), int'(e[1]));
            if (out1) pc1++;
            if (out4) pc4++;
        end
    end

    initial begin
        // reset idle
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);   // reset dominates in
        steps(1'b0, 5);
        scenario_end("reset_idle", 0, 0);

        // single press held, exactly STABLE_CYCLES=4 samples for dut4
        steps(1'b0, 2);
        steps(1'b1, 4);
        scenario_end("single", 1, 1);

        // long hold: still one pulse
        steps(1'b1, 20);
        scenario_end("long_hold", 1, 1);

        // re-press 1,1,0,0,1,1
        steps(1'b1, 2);
        steps(1'b0, 2);
        steps(1'b1, 2);
        scenario_end("repress", 2, 0);

        // 3-sample glitch
        steps(1'b1, 3);
        scenario_end("glitch3", 1, 0);

        // reset on the edge dut1 enters PULSE, then keep pressing
        steps(1'b1, 1);
`ifdef USER_INPUT_SYNC_EN
        steps(1'b1, 2);
`endif
        step(1'b1, 1'b1);
        steps(1'b1, 8);
        scenario_end("reset_mid", 1, 1);

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) != 0));
        steps(1'b0, 10);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
